// File: rtl/boot_mem_pkg.sv
// Shared state encoding and address/byte-lane helpers for the banked boot memory.
package boot_mem_pkg;

  typedef logic [1:0] state_e;
  localparam state_e ST_CLEAR  = 2'd0;
  localparam state_e ST_OPEN   = 2'd1;
  localparam state_e ST_LOCKED = 2'd2;

  // Words are interleaved across banks on the low address bits.
  function automatic int unsigned bank_of(int unsigned addr, int unsigned num_banks);
    return addr % num_banks;
  endfunction

  function automatic int unsigned row_of(int unsigned addr, int unsigned num_banks);
    return addr / num_banks;
  endfunction

  // Byte lane owning a data bit; the top lane may be narrower than 8 bits.
  function automatic int unsigned lane_of(int unsigned bit_idx);
    return bit_idx / 8;
  endfunction

  function automatic int unsigned num_lanes(int unsigned data_width);
    return (data_width + 7) / 8;
  endfunction

endpackage

// File: rtl/boot_mem_if.sv
// Core-side OBI-style request/response port of the boot memory.
interface boot_mem_if
  import boot_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = 10
) ();
  localparam int unsigned BE_W = num_lanes(DATA_WIDTH);

  logic                  req;
  logic                  gnt;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_W-1:0]       be;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (output req, we, addr, wdata, be, input  gnt, rvalid, rdata, err);
  modport slave  (input  req, we, addr, wdata, be, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/boot_mem_bank.sv
// Single-port byte-enabled SRAM bank with a registered read port.
module boot_mem_bank
  import boot_mem_pkg::*;
#(
  parameter string       INIT_FILE  = "",
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned BANK_IDX   = 0,
  localparam int unsigned BE_W      = num_lanes(DATA_WIDTH),
  localparam int unsigned ROW_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  en,
  input  logic                  we,
  input  logic [ROW_W-1:0]      row,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_W-1:0]       be,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] bmask;

  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_mask
    assign bmask[j] = be[lane_of(j)];
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int j = 0; j < DATA_WIDTH; j++)
          if (bmask[j]) mem[row][j] <= wdata[j];
      end else begin
        rdata <= mem[row];
      end
    end
  end

endmodule

// File: rtl/boot_mem_ctrl.sv
// Banked boot memory: reset-time clear, open load phase, sticky write lock.
module boot_mem_ctrl
  import boot_mem_pkg::*;
#(
  parameter string       INIT_FILE      = "",
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WORDS      = 1024,
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  boot_mem_if.slave bus,
  input  logic      lock_i,
  output logic      locked_o,
  output logic      init_done_o
);

  localparam int unsigned ROWS   = NUM_WORDS / NUM_BANKS;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned STAGES = READ_LATENCY - 1;

  typedef struct packed {
    logic              we;
    logic              err;
    logic [BANK_W-1:0] bank;
  } meta_t;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] clr_cnt_q;
  logic             done_q;
  logic             clearing, wr_ok, fire;

  assign clearing    = (state_q == ST_CLEAR);
  assign wr_ok       = (state_q == ST_OPEN);
  assign locked_o    = (state_q == ST_LOCKED);
  assign init_done_o = done_q;
  assign bus.gnt     = done_q;
  assign fire        = bus.req & done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_cnt_q == ROW_W'(ROWS - 1)) state_d = ST_OPEN;
      ST_OPEN:  if (lock_i) state_d = ST_LOCKED;
      default:  state_d = ST_LOCKED;
    endcase
  end

  // done_q tracks "not clearing" one register later than state_d, so it
  // stays low through reset and rises together with OPEN entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_OPEN;
      clr_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clearing ? clr_cnt_q + ROW_W'(1) : clr_cnt_q;
      done_q    <= (state_d != ST_CLEAR);
    end
  end

  logic [BANK_W-1:0]                    req_bank;
  logic [ROW_W-1:0]                     req_row;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;

  assign req_bank = BANK_W'(bank_of(32'(bus.addr), NUM_BANKS));
  assign req_row  = ROW_W'(row_of(32'(bus.addr), NUM_BANKS));

  // Clear drives every bank at the same row; locked writes degrade to a harmless read.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel;
    assign sel = fire && (req_bank == BANK_W'(b));

    boot_mem_bank #(
      .INIT_FILE (INIT_FILE),
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (ROWS),
      .NUM_BANKS (NUM_BANKS),
      .BANK_IDX  (b)
    ) u_bank (
      .clk_i,
      .en   (clearing | sel),
      .we   (clearing | (bus.we & wr_ok)),
      .row  (clearing ? clr_cnt_q : req_row),
      .wdata(clearing ? '0 : bus.wdata),
      .be   (clearing ? '1 : bus.be),
      .rdata(bank_rdata[b])
    );
  end

  meta_t            meta_in;
  logic  [STAGES:0] vld_pipe;
  meta_t [STAGES:0] meta_pipe;

  assign meta_in.we   = bus.we;
  assign meta_in.err  = bus.we & ~wr_ok;
  assign meta_in.bank = req_bank;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe  <= '0;
      meta_pipe <= '0;
    end else begin
      vld_pipe[0]  <= fire;
      meta_pipe[0] <= meta_in;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        meta_pipe[k] <= meta_pipe[k-1];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rsp_data, rdata_q;

  assign rsp_data = meta_pipe[0].we ? '0 : bank_rdata[meta_pipe[0].bank];

  // rdata_q is the hold register at latency 1 and the output stage at latency 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          rdata_q <= '0;
    else if (vld_pipe[0]) rdata_q <= rsp_data;
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.rdata = vld_pipe[0] ? rsp_data : rdata_q;
  end else begin : g_lat2
    assign bus.rdata = rdata_q;
  end

  assign bus.rvalid = vld_pipe[STAGES];
  assign bus.err    = vld_pipe[STAGES] & meta_pipe[STAGES].err;

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Directed bench: 32-bit/latency-1 instance driven from a vector table, 20-bit/latency-2 instance by hand.
module tb_boot_mem_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb, lock_a, lock_b, locked_a, locked_b, done_a, done_b;

  boot_mem_if #(.DATA_WIDTH(32), .ADDR_W(10)) ifa ();
  boot_mem_if #(.DATA_WIDTH(20), .ADDR_W(6))  ifb ();

  boot_mem_ctrl #(
    .DATA_WIDTH(32), .NUM_WORDS(1024), .NUM_BANKS(2), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_na), .bus(ifa), .lock_i(lock_a), .locked_o(locked_a), .init_done_o(done_a)
  );

  boot_mem_ctrl #(
    .DATA_WIDTH(20), .NUM_WORDS(64), .NUM_BANKS(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .bus(ifb), .lock_i(lock_b), .locked_o(locked_b), .init_done_o(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        lock;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_locked;
  } vec_t;

  vec_t vecs [17];

  // One transaction on instance A, then an idle cycle to check single response and hold.
  task automatic run_vec_a(input vec_t v, input int idx);
    ifa.req = 1'b1; ifa.we = v.we; ifa.addr = v.addr; ifa.wdata = v.wdata; ifa.be = v.be;
    lock_a = v.lock;
    chk1($sformatf("v%0d gnt", idx), ifa.gnt, 1'b1);
    step();
    ifa.req = 1'b0; ifa.we = 1'b0; lock_a = 1'b0;
    chk1($sformatf("v%0d rvalid", idx), ifa.rvalid, 1'b1);
    chk($sformatf("v%0d rdata", idx), ifa.rdata, v.exp_rdata);
    chk1($sformatf("v%0d err", idx), ifa.err, v.exp_err);
    chk1($sformatf("v%0d locked", idx), locked_a, v.exp_locked);
    step();
    chk1($sformatf("v%0d single rvalid", idx), ifa.rvalid, 1'b0);
    chk($sformatf("v%0d rdata hold", idx), ifa.rdata, v.exp_rdata);
  endtask

  task automatic wait_init_a(input string tag);
    int n = 0;
    int nd = -1;
    while (n < 2000) begin
      step();
      n++;
      if (done_a && nd < 0) nd = n;
      if (ifa.gnt) break;
    end
    chk({tag, " clear cycles"}, 32'(n), 32'd512);
    chk({tag, " init_done cycle"}, 32'(nd), 32'd512);
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [5:0] addr,
                         input logic [19:0] wd, input logic [2:0] be, input logic lk);
    ifb.req = req; ifb.we = we; ifb.addr = addr; ifb.wdata = wd; ifb.be = be; lock_b = lk;
  endtask

  logic [31:0] pexp [8];
  vec_t v;

  initial begin
    rst_na = 1'b0; rst_nb = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
    ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0; ifa.be = '0;
    drive_b(1'b0, 1'b0, 6'd0, 20'h0, 3'b000, 1'b0);

    //          we    addr     wdata         be    lock  exp_rdata     err   locked
    vecs[0]  = '{1'b0, 10'h3FF, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 10'h005, 32'hDEADBEEF, 4'h5, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 10'h005, 32'h0,        4'h0, 1'b0, 32'h00AD00EF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 10'h006, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 10'h006, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 10'h006, 32'h11223344, 4'h8, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b0, 10'h006, 32'h0,        4'h0, 1'b0, 32'h11FEF00D, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 10'h004, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b1, 10'h003, 32'h33333333, 4'hF, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b1, 10'h001, 32'h01234567, 4'h3, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b0, 10'h001, 32'h0,        4'h0, 1'b0, 32'h00004567, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 10'h00A, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h0,        1'b0, 1'b1};
    vecs[12] = '{1'b1, 10'h00B, 32'h12345678, 4'hF, 1'b0, 32'h0,        1'b1, 1'b1};
    vecs[13] = '{1'b0, 10'h00A, 32'h0,        4'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 10'h005, 32'h12345678, 4'hF, 1'b0, 32'h0,        1'b1, 1'b1};
    vecs[15] = '{1'b0, 10'h005, 32'h0,        4'h0, 1'b0, 32'h00AD00EF, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 10'h00B, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b1};
    pexp = '{32'h0, 32'h00004567, 32'h0, 32'h33333333, 32'h0, 32'h00AD00EF, 32'h11FEF00D, 32'h0};

    step();
    chk1("rst gnt", ifa.gnt, 1'b0);
    chk1("rst rvalid", ifa.rvalid, 1'b0);
    chk("rst rdata", ifa.rdata, 32'h0);
    chk1("rst err", ifa.err, 1'b0);
    chk1("rst locked", locked_a, 1'b0);
    chk1("rst init_done", done_a, 1'b0);
    chk1("rst b gnt", ifb.gnt, 1'b0);
    chk1("rst b init_done", done_b, 1'b0);
    step();
    rst_na = 1'b1; rst_nb = 1'b1;
    wait_init_a("first");

    for (int i = 0; i < 17; i++) run_vec_a(vecs[i], i);

    // Eight back-to-back reads across both banks, one response per cycle in order.
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk1($sformatf("pipe%0d rvalid", i - 1), ifa.rvalid, 1'b1);
        chk($sformatf("pipe%0d rdata", i - 1), ifa.rdata, pexp[i-1]);
      end
      if (i < 8) begin
        ifa.req = 1'b1; ifa.we = 1'b0; ifa.addr = 10'(i);
        chk1($sformatf("pipe%0d gnt", i), ifa.gnt, 1'b1);
      end else begin
        ifa.req = 1'b0;
      end
      step();
    end
    chk1("pipe drained", ifa.rvalid, 1'b0);
    chk1("lock sticky", locked_a, 1'b1);

    // Latency-2, 20-bit instance: partial top lane and read-after-write back to back.
    drive_b(1'b1, 1'b1, 6'd9, 20'hFFFFF, 3'b100, 1'b0);
    chk1("b gnt", ifb.gnt, 1'b1);
    step();
    drive_b(1'b1, 1'b0, 6'd9, 20'h0, 3'b000, 1'b0);
    chk1("b lat2 no early rvalid", ifb.rvalid, 1'b0);
    step();
    drive_b(1'b0, 1'b0, 6'd0, 20'h0, 3'b000, 1'b0);
    chk1("b wr rvalid", ifb.rvalid, 1'b1);
    chk("b wr rdata", 32'(ifb.rdata), 32'h0);
    step();
    chk1("b rd rvalid", ifb.rvalid, 1'b1);
    chk("b partial lane", 32'(ifb.rdata), 32'h000F0000);
    chk1("b rd err", ifb.err, 1'b0);
    step();
    chk1("b single rvalid", ifb.rvalid, 1'b0);
    chk("b rdata hold", 32'(ifb.rdata), 32'h000F0000);

    drive_b(1'b1, 1'b1, 6'd2, 20'h12345, 3'b111, 1'b1);
    step();
    drive_b(1'b1, 1'b1, 6'd3, 20'hABCDE, 3'b111, 1'b0);
    chk1("b locked", locked_b, 1'b1);
    step();
    drive_b(1'b1, 1'b0, 6'd2, 20'h0, 3'b000, 1'b0);
    chk1("b lock-cycle wr rvalid", ifb.rvalid, 1'b1);
    chk1("b lock-cycle wr err", ifb.err, 1'b0);
    step();
    drive_b(1'b1, 1'b0, 6'd3, 20'h0, 3'b000, 1'b0);
    chk1("b locked wr rvalid", ifb.rvalid, 1'b1);
    chk1("b locked wr err", ifb.err, 1'b1);
    step();
    drive_b(1'b0, 1'b0, 6'd0, 20'h0, 3'b000, 1'b0);
    chk("b lock-cycle wr landed", 32'(ifb.rdata), 32'h00012345);
    chk1("b rd err after lock", ifb.err, 1'b0);
    step();
    chk1("b rejected rvalid", ifb.rvalid, 1'b1);
    chk("b rejected wr", 32'(ifb.rdata), 32'h0);

    // Reset, then reset again at clear row 100: the clear must restart from row 0.
    rst_na = 1'b0;
    #1;
    chk1("rst2 locked", locked_a, 1'b0);
    step();
    rst_na = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst_na = 1'b0;
    #1;
    chk1("midclr locked", locked_a, 1'b0);
    chk1("midclr gnt", ifa.gnt, 1'b0);
    chk1("midclr init_done", done_a, 1'b0);
    chk1("midclr rvalid", ifa.rvalid, 1'b0);
    step();
    rst_na = 1'b1;
    wait_init_a("restart");

    v = '{1'b0, 10'h005, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    run_vec_a(v, 100);
    v = '{1'b1, 10'h3FF, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0};
    run_vec_a(v, 101);
    v = '{1'b0, 10'h3FF, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 1'b0, 1'b0};
    run_vec_a(v, 102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
